// File: rtl/fx_pkg.sv
// Shared constants for the fx_hub read concentrator: field widths, miss data
// and FSM state encodings.
package fx_pkg;

  localparam int FX_ID_W    = 6;
  localparam int FX_LADDR_W = 10;
  localparam int FX_DATA_W  = 8;

  localparam logic [FX_DATA_W-1:0] FX_MISS_DATA = 8'hEE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Saturating increment for 8-bit statistics counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/fx_id_dec.sv
// Module-id decoder: maps a 6-bit id onto the lowest slot whose MOD_IDS entry
// matches it, reporting hit when any slot matches.
module fx_id_dec
  import fx_pkg::*;
#(
  parameter int                         N_SLV   = 8,
  parameter int                         IDX_W   = 3,
  parameter logic [N_SLV*FX_ID_W-1:0]   MOD_IDS = '0
) (
  input  logic [FX_ID_W-1:0] id,
  output logic [IDX_W-1:0]   idx,
  output logic               hit
);

  // Scanning from the top slot down lets the lowest matching slot win.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (MOD_IDS[i*FX_ID_W +: FX_ID_W] == id) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fx_hub.sv
// Read concentrator: one read in flight, fixed slave latency, registered return
// data. Statistics counters exist only when FX_HUB_STAT_EN is defined.
module fx_hub
  import fx_pkg::*;
#(
  parameter int                       N_SLV     = 8,
  parameter int                       RD_LAT    = 2,
  parameter logic [N_SLV*FX_ID_W-1:0] MOD_IDS   = {6'h22, 6'h21, 6'h20, 6'h13,
                                                   6'h12, 6'h11, 6'h02, 6'h01},
  parameter logic [FX_DATA_W-1:0]     MISS_DATA = FX_MISS_DATA
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       fx_rd,
  input  logic [15:0]                fx_raddr,
  input  logic [N_SLV*FX_DATA_W-1:0] fx_q_slv,
  input  logic                       stat_clr,
  output logic [FX_DATA_W-1:0]       fx_q,
  output logic                       fx_q_vld,
  output logic                       fx_busy,
  output logic [7:0]                 miss_cnt,
  output logic [7:0]                 ovl_cnt
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  logic [1:0]           state;
  logic [3:0]           lat_cnt;
  logic [IDX_W-1:0]     idx_q;
  logic                 miss_q;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_hit;
  logic [FX_DATA_W-1:0] slot_data;
  logic [FX_LADDR_W-1:0] unused_laddr;

  assign unused_laddr = fx_raddr[FX_LADDR_W-1:0];

  fx_id_dec #(
    .N_SLV   (N_SLV),
    .IDX_W   (IDX_W),
    .MOD_IDS (MOD_IDS)
  ) u_dec (
    .id  (fx_raddr[FX_LADDR_W +: FX_ID_W]),
    .idx (dec_idx),
    .hit (dec_hit)
  );

  assign slot_data = fx_q_slv[idx_q*FX_DATA_W +: FX_DATA_W];
  assign fx_busy   = (state != ST_IDLE);

  // Return data is captured on the edge entering DONE, which is exactly when
  // the slave data becomes valid RD_LAT cycles after the strobe.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      idx_q    <= '0;
      miss_q   <= 1'b0;
      fx_q     <= '0;
      fx_q_vld <= 1'b0;
    end else begin
      fx_q_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fx_rd) begin
            idx_q   <= dec_idx;
            miss_q  <= !dec_hit;
            lat_cnt <= 4'(RD_LAT);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd1) begin
            fx_q     <= miss_q ? MISS_DATA : slot_data;
            fx_q_vld <= 1'b1;
            state    <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FX_HUB_STAT_EN
  logic miss_evt;
  logic ovl_evt;

  assign miss_evt = (state == ST_IDLE) && fx_rd && !dec_hit;
  assign ovl_evt  = (state != ST_IDLE) && fx_rd;

  // A clear takes priority over any increment in the same cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
      ovl_cnt  <= '0;
    end else if (stat_clr) begin
      miss_cnt <= '0;
      ovl_cnt  <= '0;
    end else begin
      if (miss_evt) miss_cnt <= sat_inc(miss_cnt);
      if (ovl_evt)  ovl_cnt  <= sat_inc(ovl_cnt);
    end
  end
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign miss_cnt        = 8'h00;
  assign ovl_cnt         = 8'h00;
`endif

endmodule

// File: doc/fx_hub.md
FX_HUB -- requirements
Module: fx_hub

Interface
REQ-001 SHALL have parameter N_SLV, default 8, number of slave read-data ports (1..32).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from fx_rd to valid slave fx_q (1..15).
REQ-003 SHALL have parameter MOD_IDS, default {6'h22,6'h21,6'h20,6'h13,6'h12,6'h11,6'h02,6'h01}, flat N_SLV*6 list; slot i = bits [6i+5:6i].
REQ-004 SHALL have parameter MISS_DATA, default 8'hEE, data returned on unmatched address.
REQ-005 clk_sys  input  1  system clock; the only clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 fx_rd  input  1  one-cycle read strobe.
REQ-008 fx_raddr  input  16  read address; [15:10] module id, [9:0] local address.
REQ-009 fx_q_slv  input  N_SLV*8  slave read data, slot i = bits [8i+7:8i].
REQ-010 stat_clr  input  1  synchronous clear of statistics.
REQ-011 fx_q  output  8  registered read data to control_top.
REQ-012 fx_q_vld  output  1  one-cycle pulse, fx_q valid.
REQ-013 fx_busy  output  1  high while a read is in flight.
REQ-014 miss_cnt  output  8  unmatched-read counter.
REQ-015 ovl_cnt  output  8  reads dropped while busy.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-017 IDLE: on fx_rd, latch fx_raddr[15:10], decode to slot index, load latency counter with RD_LAT, go WAIT.
REQ-018 Decode SHALL pick the lowest slot i whose MOD_IDS entry equals the id; no match sets an internal miss flag.
REQ-019 WAIT: counter decrements each cycle; on reaching 1 go DONE.
REQ-020 DONE: register fx_q = selected slot data (or MISS_DATA if miss), assert fx_q_vld for exactly this cycle, return IDLE.
REQ-021 fx_q_vld SHALL therefore rise RD_LAT+1 cycles after the fx_rd cycle; fx_q SHALL hold its value until the next DONE.
REQ-022 fx_busy SHALL be high in WAIT and DONE, low in IDLE.
REQ-023 fx_rd in WAIT or DONE SHALL be ignored (no restart) and counted in ovl_cnt.
REQ-024 fx_rd in the IDLE cycle immediately after DONE SHALL be accepted normally (back-to-back reads every RD_LAT+2 cycles).
REQ-025 Counters SHALL saturate at 8'hFF, never wrap.
REQ-026 stat_clr SHALL zero both counters; if coincident with an increment event, clear wins.
REQ-027 Slave data outside the DONE cycle SHALL have no effect on fx_q.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, fx_q 8'h00, fx_q_vld 0, fx_busy 0, counters 0, latched index 0.
REQ-029 Reset mid-read SHALL abort it with no fx_q_vld pulse after release.
REQ-030 First read SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro FX_HUB_STAT_EN: defined -> miss_cnt and ovl_cnt counters per REQ-023/025/026.
REQ-032 Not defined -> miss_cnt and ovl_cnt tied 8'h00, counter logic absent, stat_clr unused; all other behaviour identical.

Structure
REQ-033 Shared package fx_pkg SHALL hold FX_ID_W=6, FX_LADDR_W=10, FX_DATA_W=8, MISS_DATA default, and FSM state encodings.
REQ-034 Decode SHALL be a sub-module fx_id_dec (id + MOD_IDS -> index, hit); FSM, counters and data register stay in fx_hub.

Verification
REQ-035 RD_LAT=2, fx_raddr=16'h4400 (id 6'h11), slot 2 data 8'h5A -> fx_q=8'h5A, fx_q_vld pulse 3 cycles after fx_rd, fx_busy high 3 cycles.
REQ-036 fx_raddr=16'hFC00 (id 6'h3F, unmapped) -> fx_q=8'hEE, miss_cnt 0->1.
REQ-037 Second fx_rd one cycle after first -> single fx_q_vld, data from first address, ovl_cnt=1; read issued on cycle after DONE -> served.
REQ-038 MOD_IDS with slots 3 and 5 both 6'h20, read id 6'h20 -> slot 3 data returned.
REQ-039 rst_n pulsed low during WAIT -> no fx_q_vld, all outputs zero, next read after release correct.
REQ-040 300 unmapped reads -> miss_cnt=8'hFF; stat_clr with coincident miss -> 8'h00; build without FX_HUB_STAT_EN -> counters always 8'h00.
